collision_detect: RTL

- Upstream stage of the ball position controller in the Pong datapath.
- Compares the current ball coordinates against the screen walls and both paddle rectangles, and produces clean, debounced vertical/horizontal collision pulses.
- Those pulses' rising edges flip the ball direction. The block also detects missed balls, keeps both scores, issues a serve request and flags game over.

---
 rtl/pong_pkg.sv | 24 ++
 rtl/col_pulse_fsm.sv | 69 ++++++
 rtl/collision_detect.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared Pong screen geometry and FSM state encodings used by the
// collision and scoring logic.
package pong_pkg;

  localparam int unsigned SCREEN_W       = 640;
  localparam int unsigned SCREEN_H       = 480;
  localparam int unsigned BALL_SIZE      = 8;
  localparam int unsigned PADDLE_W       = 8;
  localparam int unsigned PADDLE_H       = 64;
  localparam int unsigned LEFT_PADDLE_X  = 16;
  localparam int unsigned RIGHT_PADDLE_X = 616;

  typedef enum logic [1:0] {
    AX_READY,
    AX_PULSE,
    AX_GUARD
  } axisState_e;

  typedef enum logic {
    SRV_PLAY,
    SRV_HOLD
  } serveState_e;

endpackage

// File: rtl/col_pulse_fsm.sv
// Per-axis collision debouncer: turns a detected contact into a fixed-length
// pulse, then ignores further contacts on this axis for a number of move ticks.
module col_pulse_fsm
  import pong_pkg::*;
#(
  parameter int unsigned PULSE_LEN   = 4,
  parameter int unsigned GUARD_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic eval,
  input  logic hit,
  input  logic enable,
  output logic pulse
);

  localparam int unsigned CNT_MAX = (PULSE_LEN > GUARD_TICKS) ? PULSE_LEN : GUARD_TICKS;
  localparam int          CW      = $clog2(CNT_MAX + 1);

  axisState_e    state;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= AX_READY;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      case (state)
        AX_READY: begin
          if (eval && hit && enable) begin
            state <= AX_PULSE;
            cnt   <= '0;
            pulse <= 1'b1;
          end
        end
        AX_PULSE: begin
          if (cnt == CW'(PULSE_LEN - 1)) begin
            state <= AX_GUARD;
            cnt   <= '0;
            pulse <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        AX_GUARD: begin
          // Contacts are dropped here; only move ticks advance the guard.
          if (tick) begin
            if (cnt == CW'(GUARD_TICKS - 1)) begin
              state <= AX_READY;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= AX_READY;
          cnt   <= '0;
          pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/collision_detect.sv
// Ball-vs-wall/paddle collision detection with debounced direction-flip
// pulses, miss detection, scoring, serve request and game-over latch.
module collision_detect
  import pong_pkg::*;
#(
  parameter int unsigned PULSE_LEN   = 4,
  parameter int unsigned GUARD_TICKS = 4,
  parameter int unsigned SERVE_HOLD  = 16,
  parameter int unsigned SCORE_MAX   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [9:0] xCoord,
  input  logic [8:0] yCoord,
  input  logic [8:0] lPaddleY,
  input  logic [8:0] rPaddleY,
  output logic       vCol,
  output logic       hCol,
  output logic [3:0] lScore,
  output logic [3:0] rScore,
  output logic       serve,
  output logic       gameOver
);

  localparam int HW = $clog2(SERVE_HOLD + 1);

  logic        eval;
  logic [10:0] xRight;
  logic [9:0]  yBottom;
  logic [9:0]  lPadBottom;
  logic [9:0]  rPadBottom;
  logic        wallHit;
  logic        lPadHit;
  logic        rPadHit;
  logic        paddleHit;
  logic        lScores;
  logic        rScores;

  serveState_e   srvState;
  logic [HW-1:0] holdCnt;

  // Coordinates move on tick, so they are judged one clock later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) eval <= 1'b0;
    else       eval <= tick;
  end

  // Edge sums carry one extra bit so they cannot wrap near the screen limits.
  assign xRight     = {1'b0, xCoord}   + 11'(BALL_SIZE);
  assign yBottom    = {1'b0, yCoord}   + 10'(BALL_SIZE);
  assign lPadBottom = {1'b0, lPaddleY} + 10'(PADDLE_H);
  assign rPadBottom = {1'b0, rPaddleY} + 10'(PADDLE_H);

  assign wallHit = (yCoord == '0) || (yBottom >= 10'(SCREEN_H));

  assign lPadHit = (xCoord >= 10'(LEFT_PADDLE_X))
                && (xCoord <= 10'(LEFT_PADDLE_X + PADDLE_W))
                && (yBottom > {1'b0, lPaddleY})
                && ({1'b0, yCoord} < lPadBottom);

  assign rPadHit = (xRight >= 11'(RIGHT_PADDLE_X))
                && (xRight <= 11'(RIGHT_PADDLE_X + PADDLE_W))
                && (yBottom > {1'b0, rPaddleY})
                && ({1'b0, yCoord} < rPadBottom);

  assign paddleHit = lPadHit || rPadHit;
  assign rScores   = (xCoord == '0) && !paddleHit;
  assign lScores   = (xRight >= 11'(SCREEN_W)) && !paddleHit;

  col_pulse_fsm #(
    .PULSE_LEN  (PULSE_LEN),
    .GUARD_TICKS(GUARD_TICKS)
  ) u_vAxis (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .eval  (eval),
    .hit   (wallHit),
    .enable(!gameOver),
    .pulse (vCol)
  );

  col_pulse_fsm #(
    .PULSE_LEN  (PULSE_LEN),
    .GUARD_TICKS(GUARD_TICKS)
  ) u_hAxis (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .eval  (eval),
    .hit   (paddleHit),
    .enable(!gameOver),
    .pulse (hCol)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srvState <= SRV_PLAY;
      holdCnt  <= '0;
      serve    <= 1'b0;
      lScore   <= '0;
      rScore   <= '0;
      gameOver <= 1'b0;
    end else begin
      // NOTE: a later non-blocking assignment in the same block overrides this
      // default, which keeps serve a single-clock pulse.
      serve <= 1'b0;
      case (srvState)
        SRV_PLAY: begin
          if (eval && !gameOver && (lScores || rScores)) begin
            serve    <= 1'b1;
            srvState <= SRV_HOLD;
            holdCnt  <= '0;
            if (lScores) begin
              if (lScore < 4'(SCORE_MAX))      lScore   <= lScore + 4'd1;
              if (lScore == 4'(SCORE_MAX - 1)) gameOver <= 1'b1;
            end else begin
              if (rScore < 4'(SCORE_MAX))      rScore   <= rScore + 4'd1;
              if (rScore == 4'(SCORE_MAX - 1)) gameOver <= 1'b1;
            end
          end
        end
        SRV_HOLD: begin
          if (tick) begin
            if (holdCnt == HW'(SERVE_HOLD - 1)) begin
              srvState <= SRV_PLAY;
              holdCnt  <= '0;
            end else begin
              holdCnt <= holdCnt + HW'(1);
            end
          end
        end
        default: begin
          srvState <= SRV_PLAY;
          holdCnt  <= '0;
        end
      endcase
    end
  end

endmodule
